// File: rtl/fp16_align_add.sv
// FP16 add front end: unpack/swap, align/add, left-normalize into fp16_normalize.
// Latency 3 cycles, one op/cycle; stages stall via valid/ready, in_ready is combinational from out_ready.
module fp16_align_add #(
  parameter int EXP_W   = 5,
  parameter int FRAC_W  = 10,
  parameter int GUARD_W = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_W+FRAC_W:0]         a,
  input  logic [EXP_W+FRAC_W:0]         b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FRAC_W+GUARD_W+1:0]     out_mant_sum,
  output logic [EXP_W-1:0]              out_exp_half,
  output logic                          out_sign_half
);

  localparam int MANT_W = 1 + FRAC_W + GUARD_W;
  localparam int OP_W   = 1 + EXP_W + FRAC_W;
  localparam int LZ_W   = $clog2(MANT_W + 1);
  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(MANT_W);

  typedef struct packed {
    logic              special;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic              sub;
    logic [EXP_W-1:0]  shift;
    logic [MANT_W-1:0] mant_l;
    logic [MANT_W-1:0] mant_s;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   sum;
  } s2_t;

  function automatic logic [LZ_W-1:0] lzc(input logic [MANT_W-1:0] v);
    lzc = LZ_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (v[i]) lzc = LZ_W'(MANT_W - 1 - i);
    end
  endfunction

  logic v1, v2;
  logic adv2, adv3;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign adv3     = !out_valid || out_ready;
  assign adv2     = !v2 || adv3;
  assign in_ready = !v1 || adv2;

  // ---------------- S1: unpack and order by magnitude ----------------
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [MANT_W-1:0] mant_a, mant_b;
  logic              a_ge_b;

  assign exp_a  = a[OP_W-2 -: EXP_W];
  assign exp_b  = b[OP_W-2 -: EXP_W];
  assign frac_a = a[FRAC_W-1:0];
  assign frac_b = b[FRAC_W-1:0];
  // Subnormals are flushed to zero here, so a zero exponent means a zero mantissa.
  assign mant_a = (exp_a == '0) ? '0 : {1'b1, frac_a, {GUARD_W{1'b0}}};
  assign mant_b = (exp_b == '0) ? '0 : {1'b1, frac_b, {GUARD_W{1'b0}}};
  assign a_ge_b = a[OP_W-2:0] >= b[OP_W-2:0];

  always_comb begin
    s1_d     = '0;
    s1_d.sub = a[OP_W-1] ^ b[OP_W-1];
    if (exp_a == EXP_MAX) begin
      s1_d.special = 1'b1;
      s1_d.sign    = a[OP_W-1];
      s1_d.exp     = EXP_MAX;
      s1_d.mant_l  = {1'b1, frac_a, {GUARD_W{1'b0}}};
    end else if (exp_b == EXP_MAX) begin
      s1_d.special = 1'b1;
      s1_d.sign    = b[OP_W-1];
      s1_d.exp     = EXP_MAX;
      s1_d.mant_l  = {1'b1, frac_b, {GUARD_W{1'b0}}};
    end else if (a_ge_b) begin
      s1_d.sign   = a[OP_W-1];
      s1_d.exp    = exp_a;
      s1_d.shift  = exp_a - exp_b;
      s1_d.mant_l = mant_a;
      s1_d.mant_s = mant_b;
    end else begin
      s1_d.sign   = b[OP_W-1];
      s1_d.exp    = exp_b;
      s1_d.shift  = exp_b - exp_a;
      s1_d.mant_l = mant_b;
      s1_d.mant_s = mant_a;
    end
  end

  // ---------------- S2: align smaller operand and add/subtract ----------------
  logic [MANT_W-1:0] mant_s_aligned;

  assign mant_s_aligned = (s1_q.shift >= SHIFT_LIM) ? '0 : (s1_q.mant_s >> s1_q.shift);

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.exp  = s1_q.exp;
    // Specials ride through as {0,1,frac,000} so S3 passes them unchanged (lz=0).
    if (s1_q.special) begin
      s2_d.sum = {1'b0, s1_q.mant_l};
    end else if (s1_q.sub) begin
      s2_d.sum = {1'b0, s1_q.mant_l} - {1'b0, mant_s_aligned};
    end else begin
      s2_d.sum = {1'b0, s1_q.mant_l} + {1'b0, mant_s_aligned};
    end
  end

  // ---------------- S3: left normalize ----------------
  logic [LZ_W-1:0]  lz;
  logic [MANT_W:0]  s3_mant;
  logic [EXP_W-1:0] s3_exp;
  logic             s3_sign;

  assign lz = lzc(s2_q.sum[MANT_W-1:0]);

  always_comb begin
    s3_mant = s2_q.sum;
    s3_exp  = s2_q.exp;
    s3_sign = s2_q.sign;
    // A carry out (top bit) is left for the downstream right shift.
    if (!s2_q.sum[MANT_W]) begin
      if (s2_q.sum == '0) begin
        s3_mant = '0;
        s3_exp  = '0;
        s3_sign = 1'b0;
      end else if (int'(lz) >= int'(s2_q.exp)) begin
        s3_mant = '0;
        s3_exp  = '0;
      end else begin
        s3_mant = s2_q.sum << lz;
        s3_exp  = s2_q.exp - EXP_W'(lz);
      end
    end
  end

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      out_valid     <= 1'b0;
      s1_q          <= '0;
      s2_q          <= '0;
      out_mant_sum  <= '0;
      out_exp_half  <= '0;
      out_sign_half <= 1'b0;
    end else begin
      if (in_ready) begin
        v1 <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) s2_q <= s2_d;
      end
      if (adv3) begin
        out_valid <= v2;
        if (v2) begin
          out_mant_sum  <= s3_mant;
          out_exp_half  <= s3_exp;
          out_sign_half <= s3_sign;
        end
      end
    end
  end

endmodule
